// File: rtl/csr_arb_pkg.sv
// Shared types and defaults for the CSR access arbiter: FSM state encoding,
// default bus widths and the implemented-CSR decode limit.
package csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int CSR_AW_DEF  = 16;
  localparam int CSR_DW_DEF  = 32;
  localparam int CSR_NUM_CSR = 32;

  // Wide enough for READ_LAT-1 with READ_LAT up to 4.
  localparam int CSR_CNT_W   = 2;

endpackage

// File: rtl/csr_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping, returned as both a one-hot vector and a binary index.
module csr_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    int unsigned pos;
    pos   = 0;
    idx   = '0;
    valid = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = (int'(rr_ptr) + i) % NUM_REQ;
      idx = req[pos] ? IW'(pos) : idx;
    end
    onehot = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter sharing one registered-select CSR port between NUM_REQ
// requesters, one transaction in flight. Define CSR_ARB_ADDR_CHECK_EN to reject
// selects >= NUM_CSR with rsp_err instead of issuing them.
module csr_access_arbiter
  import csr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int AW       = CSR_AW_DEF,
  parameter int DW       = CSR_DW_DEF,
  parameter int NUM_CSR  = CSR_NUM_CSR,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  csr_we,
  output logic [AW-1:0]         csr_sel,
  output logic [DW-1:0]         csr_wdata,
  input  logic [DW-1:0]         csr_rdata
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || READ_LAT < 1 || READ_LAT > 4 || NUM_CSR < 1)
  begin : g_bad_param
    $error("csr_access_arbiter: parameter out of supported range");
  end

  state_e                 state_r;
  logic [IW-1:0]          idx_r;
  logic [IW-1:0]          rr_ptr_r;
  logic                   we_r;
  logic [CSR_CNT_W-1:0]   cnt_r;
  logic [DW-1:0]          data_r;

  logic [NUM_REQ-1:0]     pick_onehot_s;
  logic [IW-1:0]          pick_idx_s;
  logic                   pick_valid_s;
  logic                   we_sel_s;
  logic [AW-1:0]          addr_sel_s;
  logic [DW-1:0]          wdata_sel_s;

  csr_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .valid  (pick_valid_s)
  );

  assign we_sel_s    = req_we[pick_idx_s];
  assign addr_sel_s  = req_addr[pick_idx_s*AW +: AW];
  assign wdata_sel_s = req_wdata[pick_idx_s*DW +: DW];

`ifdef CSR_ARB_ADDR_CHECK_EN
  logic err_r;
  logic addr_ok_s;
  assign addr_ok_s = (32'(addr_sel_s) < 32'(NUM_CSR));
`else
  assign rsp_err = 1'b0;
`endif

  // Transaction FSM; every bus-facing output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      rr_ptr_r  <= '0;
      we_r      <= 1'b0;
      cnt_r     <= '0;
      data_r    <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      csr_we    <= 1'b0;
      csr_sel   <= '0;
      csr_wdata <= '0;
`ifdef CSR_ARB_ADDR_CHECK_EN
      err_r     <= 1'b0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      csr_we    <= 1'b0;
`ifdef CSR_ARB_ADDR_CHECK_EN
      rsp_err   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            idx_r <= pick_idx_s;
            we_r  <= we_sel_s;
            gnt   <= pick_onehot_s;
`ifdef CSR_ARB_ADDR_CHECK_EN
            if (!addr_ok_s) begin
              // Rejected select never reaches the CSR file.
              err_r   <= 1'b1;
              data_r  <= '0;
              state_r <= RESP;
            end else begin
              err_r     <= 1'b0;
              csr_we    <= we_sel_s;
              csr_sel   <= addr_sel_s;
              csr_wdata <= wdata_sel_s;
              state_r   <= ISSUE;
            end
`else
            csr_we    <= we_sel_s;
            csr_sel   <= addr_sel_s;
            csr_wdata <= wdata_sel_s;
            state_r   <= ISSUE;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          cnt_r   <= CSR_CNT_W'(READ_LAT - 1);
          state_r <= WAIT;
        end
        WAIT: begin
          if (cnt_r == '0) begin
            data_r  <= we_r ? '0 : csr_rdata;
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= NUM_REQ'(1) << idx_r;
          rsp_rdata <= data_r;
`ifdef CSR_ARB_ADDR_CHECK_EN
          rsp_err   <= err_r;
`endif
          rr_ptr_r  <= (idx_r == IW'(NUM_REQ - 1)) ? '0 : idx_r + 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
